// File: rtl/line_buffer_pkg.sv
// Shared types and constants for the kernel line buffer.
//  edge_mode_t : frame-edge handling selector (RAW / CLAMP / ZERO; code 3 behaves as RAW)
//  LB_LATENCY  : input-to-output latency in clock cycles
package line_buffer_pkg;

    typedef enum logic [1:0] {
        EDGE_RAW   = 2'd0,
        EDGE_CLAMP = 2'd1,
        EDGE_ZERO  = 2'd2
    } edge_mode_t;

    localparam int LB_LATENCY = 2;

endpackage

// File: rtl/line_ram.sv
// One video line of storage: single-clock dual-port RAM, read-first,
// two-cycle read latency (array read register + output register).
//  i_clk     : clock
//  i_rst_n   : async active-low reset, clears only the output register
//  i_wr_en   : write strobe
//  i_wr_addr : write column
//  i_wr_data : write pixel
//  i_rd_addr : read column (must be < DEPTH)
//  o_rd_data : pixel read two cycles earlier
module line_ram #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 320,
    parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_stage1;
    logic [DATA_W-1:0] r_rd_stage2;

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Plain read register so the array maps onto block RAM (read-first).
    always_ff @(posedge i_clk) begin
        r_rd_stage1 <= r_mem[i_rd_addr];
    end

    // Output register is reset so the whole block shows zeros in reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_stage2 <= '0;
        end else begin
            r_rd_stage2 <= r_rd_stage1;
        end
    end

    assign o_rd_data = r_rd_stage2;

endmodule

// File: rtl/line_buffer_kernel.sv
// Rotating K+1 line buffer presenting KERNEL_ROWS vertically adjacent pixels
// per column, with frame-edge handling and a priming flag.
//  clk_in / rst_n_in : clock, async active-low reset
//  hcount_in, vcount_in, pixel_data_in, data_valid_in : pixel stream
//  edge_mode_in      : edge handling, latched on the first pixel of a frame
//  line_buffer_out   : K lanes, lane 0 (LSBs) = top row, lane K-1 = bottom row
//  hcount_out, vcount_out (center row), data_valid_out : delayed metadata
//  primed_out        : K complete lines stored since reset
module line_buffer_kernel
    import line_buffer_pkg::*;
#(
    parameter int PIXEL_WIDTH  = 16,
    parameter int H_RES        = 320,
    parameter int V_RES        = 180,
    parameter int KERNEL_ROWS  = 3,
    parameter int HCOUNT_WIDTH = 11,
    parameter int VCOUNT_WIDTH = 10
) (
    input  logic                               clk_in,
    input  logic                               rst_n_in,
    input  logic [HCOUNT_WIDTH-1:0]            hcount_in,
    input  logic [VCOUNT_WIDTH-1:0]            vcount_in,
    input  logic [PIXEL_WIDTH-1:0]             pixel_data_in,
    input  logic                               data_valid_in,
    input  logic [1:0]                         edge_mode_in,
    output logic [KERNEL_ROWS*PIXEL_WIDTH-1:0] line_buffer_out,
    output logic [HCOUNT_WIDTH-1:0]            hcount_out,
    output logic [VCOUNT_WIDTH-1:0]            vcount_out,
    output logic                               data_valid_out,
    output logic                               primed_out
);

    localparam int K      = KERNEL_ROWS;
    localparam int NRAM   = K + 1;
    localparam int SEL_W  = $clog2(NRAM);
    localparam int ADDR_W = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int HALF   = (K + 1) / 2;
    localparam int C      = (K - 1) / 2;
    localparam int VW1    = VCOUNT_WIDTH + 1;
    localparam int LAST   = LB_LATENCY - 1;

    localparam logic [HCOUNT_WIDTH-1:0] H_RES_H = HCOUNT_WIDTH'(H_RES);
    localparam logic [HCOUNT_WIDTH-1:0] H_LAST  = HCOUNT_WIDTH'(H_RES - 1);

    if (K < 3 || K > 7 || (K % 2) == 0) begin : g_bad_kernel
        $error("KERNEL_ROWS must be odd and within 3..7");
    end

    logic                    w_in_range;
    logic                    w_wr;
    logic                    w_line_end;
    logic [ADDR_W-1:0]       w_addr;
    logic [VW1-1:0]          w_vc_ext;
    logic [VCOUNT_WIDTH-1:0] w_vc_center;
    logic [PIXEL_WIDTH-1:0]  w_rd_data [NRAM];
    logic [PIXEL_WIDTH-1:0]  w_lane    [K];
    logic [PIXEL_WIDTH-1:0]  w_out     [K];

    logic [SEL_W-1:0]        r_write_sel;
    logic [SEL_W-1:0]        r_line_cnt;
    logic [1:0]              r_edge_mode;
    logic [SEL_W-1:0]        r_sel_pipe    [LB_LATENCY];
    logic [HCOUNT_WIDTH-1:0] r_hcount_pipe [LB_LATENCY];
    logic [VCOUNT_WIDTH-1:0] r_vcount_pipe [LB_LATENCY];
    logic [LB_LATENCY-1:0]   r_valid_pipe;

    // Columns past the active width never touch the RAMs; read address is
    // parked at 0 for them so it always stays inside the array.
    assign w_in_range = (hcount_in < H_RES_H);
    assign w_wr       = data_valid_in && w_in_range;
    assign w_line_end = w_wr && (hcount_in == H_LAST);
    assign w_addr     = w_in_range ? hcount_in[ADDR_W-1:0] : '0;

    // Center row lags the incoming row by (K+1)/2 lines, wrapping modulo V_RES.
    always_comb begin
        w_vc_ext = {1'b0, vcount_in} - VW1'(HALF);
        if (vcount_in < VCOUNT_WIDTH'(HALF)) begin
            w_vc_ext = w_vc_ext + VW1'(V_RES);
        end
        w_vc_center = VCOUNT_WIDTH'(w_vc_ext);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_write_sel <= '0;
            r_line_cnt  <= '0;
            r_edge_mode <= EDGE_RAW;
        end else begin
            if (w_line_end) begin
                r_write_sel <= (r_write_sel == SEL_W'(K)) ? '0 : r_write_sel + SEL_W'(1);
                if (r_line_cnt != SEL_W'(K)) begin
                    r_line_cnt <= r_line_cnt + SEL_W'(1);
                end
            end
            if (data_valid_in && hcount_in == '0 && vcount_in == '0) begin
                r_edge_mode <= edge_mode_in;
            end
        end
    end

    // Metadata and the write selector travel alongside the RAM read pipeline.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int s = 0; s < LB_LATENCY; s++) begin
                r_sel_pipe[s]    <= '0;
                r_hcount_pipe[s] <= '0;
                r_vcount_pipe[s] <= '0;
            end
            r_valid_pipe <= '0;
        end else begin
            r_sel_pipe[0]    <= r_write_sel;
            r_hcount_pipe[0] <= hcount_in;
            r_vcount_pipe[0] <= w_vc_center;
            for (int s = 1; s < LB_LATENCY; s++) begin
                r_sel_pipe[s]    <= r_sel_pipe[s-1];
                r_hcount_pipe[s] <= r_hcount_pipe[s-1];
                r_vcount_pipe[s] <= r_vcount_pipe[s-1];
            end
            r_valid_pipe <= {r_valid_pipe[LB_LATENCY-2:0], data_valid_in};
        end
    end

    for (genvar gi = 0; gi < NRAM; gi++) begin : g_ram
        line_ram #(
            .DATA_W (PIXEL_WIDTH),
            .DEPTH  (H_RES),
            .ADDR_W (ADDR_W)
        ) u_line_ram (
            .i_clk     (clk_in),
            .i_rst_n   (rst_n_in),
            .i_wr_en   (w_wr && (r_write_sel == SEL_W'(gi))),
            .i_wr_addr (w_addr),
            .i_wr_data (pixel_data_in),
            .i_rd_addr (w_addr),
            .o_rd_data (w_rd_data[gi])
        );
    end

    // The RAM just after the one being written holds the oldest line, so
    // lane i comes from RAM (sel + 1 + i) mod (K+1).
    always_comb begin
        for (int i = 0; i < K; i++) begin
            w_lane[i] = '0;
            for (int r = 0; r < NRAM; r++) begin
                if (r == (int'(r_sel_pipe[LAST]) + 1 + i) % NRAM) begin
                    w_lane[i] = w_rd_data[r];
                end
            end
        end
    end

    // Edge substitution: lane i shows row vcount_out + i - C. CLAMP replaces
    // rows above the frame with row 0 and rows below with row V_RES-1.
    always_comb begin
        int w_row;
        int w_src;
        int w_vc;
        w_row = 0;
        w_src = 0;
        w_vc  = int'(r_vcount_pipe[LAST]);
        for (int i = 0; i < K; i++) begin
            w_row    = w_vc + i - C;
            w_out[i] = w_lane[i];
            if (r_edge_mode == EDGE_CLAMP) begin
                if (w_row < 0) begin
                    w_src = C - w_vc;
                end else if (w_row >= V_RES) begin
                    w_src = V_RES - 1 - w_vc + C;
                end else begin
                    w_src = i;
                end
                w_out[i] = '0;
                for (int j = 0; j < K; j++) begin
                    if (j == w_src) begin
                        w_out[i] = w_lane[j];
                    end
                end
            end else if (r_edge_mode == EDGE_ZERO && (w_row < 0 || w_row >= V_RES)) begin
                w_out[i] = '0;
            end
        end
    end

    for (genvar gi = 0; gi < K; gi++) begin : g_pack
        assign line_buffer_out[gi*PIXEL_WIDTH +: PIXEL_WIDTH] = w_out[gi];
    end

    assign hcount_out     = r_hcount_pipe[LAST];
    assign vcount_out     = r_vcount_pipe[LAST];
    assign data_valid_out = r_valid_pipe[LB_LATENCY-1];
    assign primed_out     = (r_line_cnt == SEL_W'(K));

endmodule

// File: tb/tb_line_buffer_kernel.sv
// Directed bench for line_buffer_kernel: a K=3 and a K=5 instance share one
// 10x10 ramp stream p(f,y,x) = 256f + 10y + x + 1; probe records hold the
// hand-computed lanes expected two cycles after selected input pixels.
module tb_line_buffer_kernel;

    localparam int PW = 16;
    localparam int HR = 10;
    localparam int VR = 10;
    localparam int HW = 11;
    localparam int VW = 10;
    localparam int NV = 21;
    localparam logic [1:0] M_RAW = 2'd0, M_CLAMP = 2'd1, M_ZERO = 2'd2, M_RSVD = 2'd3;

    typedef struct packed {
        logic [7:0]       f;
        logic [7:0]       v;
        logic [7:0]       x;
        logic [3:0]       k;
        logic [7:0]       vc;
        logic [4:0][15:0] e;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [HW-1:0] hcount_in;
    logic [VW-1:0] vcount_in;
    logic [PW-1:0] pixel_in;
    logic          valid_in;
    logic [1:0]    mode_in;

    logic [3*PW-1:0] a_lb;
    logic [HW-1:0]   a_h;
    logic [VW-1:0]   a_v;
    logic            a_val, a_pr;
    logic [5*PW-1:0] b_lb;
    logic [HW-1:0]   b_h;
    logic [VW-1:0]   b_v;
    logic            b_val, b_pr;

    always #5 clk = ~clk;

    line_buffer_kernel #(.PIXEL_WIDTH(PW), .H_RES(HR), .V_RES(VR), .KERNEL_ROWS(3),
                         .HCOUNT_WIDTH(HW), .VCOUNT_WIDTH(VW)) dut_a (
        .clk_in(clk), .rst_n_in(rst_n), .hcount_in(hcount_in), .vcount_in(vcount_in),
        .pixel_data_in(pixel_in), .data_valid_in(valid_in), .edge_mode_in(mode_in),
        .line_buffer_out(a_lb), .hcount_out(a_h), .vcount_out(a_v),
        .data_valid_out(a_val), .primed_out(a_pr));

    line_buffer_kernel #(.PIXEL_WIDTH(PW), .H_RES(HR), .V_RES(VR), .KERNEL_ROWS(5),
                         .HCOUNT_WIDTH(HW), .VCOUNT_WIDTH(VW)) dut_b (
        .clk_in(clk), .rst_n_in(rst_n), .hcount_in(hcount_in), .vcount_in(vcount_in),
        .pixel_data_in(pixel_in), .data_valid_in(valid_in), .edge_mode_in(mode_in),
        .line_buffer_out(b_lb), .hcount_out(b_h), .vcount_out(b_v),
        .data_valid_out(b_val), .primed_out(b_pr));

    vec_t tbl [NV];
    int   hits [NV];
    int   n_vec = 0;
    int   n_err = 0;
    int   lines_done = 0;
    int   prev_ok = 0;
    int   pf, pv, ph, pvalid, pprobe;

    function automatic vec_t mk(int f, int v, int x, int k, int vc,
                                int e0, int e1, int e2, int e3 = 0, int e4 = 0);
        vec_t r;
        r.f = 8'(f); r.v = 8'(v); r.x = 8'(x); r.k = 4'(k); r.vc = 8'(vc);
        r.e[0] = 16'(e0); r.e[1] = 16'(e1); r.e[2] = 16'(e2);
        r.e[3] = 16'(e3); r.e[4] = 16'(e4);
        return r;
    endfunction

    function automatic logic [15:0] pix(int f, int v, int x);
        return 16'(256 * f + 10 * v + x + 1);
    endfunction

    task automatic chk(string nm, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_zero(string tag);
        chk({tag, " lanes_a"}, int'(|a_lb), 0);
        chk({tag, " lanes_b"}, int'(|b_lb), 0);
        chk({tag, " hcount"}, int'(a_h) + int'(b_h), 0);
        chk({tag, " vcount"}, int'(a_v) + int'(b_v), 0);
        chk({tag, " valid"}, int'(a_val) + int'(b_val), 0);
        chk({tag, " primed"}, int'(a_pr) + int'(b_pr), 0);
    endtask

    // Drive one beat; after the edge, check metadata of the previous beat,
    // the probe table for it, and the priming flags.
    task automatic beat(int f, int v, int h, logic valid, logic [15:0] data, logic [1:0] mode);
        string ctx;
        hcount_in = HW'(h); vcount_in = VW'(v); pixel_in = data;
        valid_in = valid; mode_in = mode;
        @(posedge clk);
        #1;
        if (valid && h == HR - 1) lines_done++;
        if (prev_ok != 0) begin
            ctx = $sformatf("f%0d v%0d x%0d", pf, pv, ph);
            chk({ctx, " hcount_a"}, int'(a_h), ph);
            chk({ctx, " hcount_b"}, int'(b_h), ph);
            chk({ctx, " valid_a"}, int'(a_val), pvalid);
            chk({ctx, " valid_b"}, int'(b_val), pvalid);
            chk({ctx, " vcount_a"}, int'(a_v), (pv + VR - 2) % VR);
            chk({ctx, " vcount_b"}, int'(b_v), (pv + VR - 3) % VR);
            if (pprobe != 0) begin
                for (int t = 0; t < NV; t++) begin
                    if (int'(tbl[t].f) == pf && int'(tbl[t].v) == pv && int'(tbl[t].x) == ph) begin
                        hits[t]++;
                        for (int j = 0; j < int'(tbl[t].k); j++) begin
                            if (tbl[t].k == 4'd3)
                                chk($sformatf("%s k3 lane%0d", ctx, j), int'(a_lb[j*PW +: PW]), int'(tbl[t].e[j]));
                            else
                                chk($sformatf("%s k5 lane%0d", ctx, j), int'(b_lb[j*PW +: PW]), int'(tbl[t].e[j]));
                        end
                        chk({ctx, " probe vcount"}, (tbl[t].k == 4'd3) ? int'(a_v) : int'(b_v), int'(tbl[t].vc));
                    end
                end
            end
        end
        chk($sformatf("f%0d v%0d x%0d primed_a", f, v, h), int'(a_pr), int'(lines_done >= 3));
        chk($sformatf("f%0d v%0d x%0d primed_b", f, v, h), int'(b_pr), int'(lines_done >= 5));
        pf = f; pv = v; ph = h; pvalid = int'(valid);
        pprobe = int'(valid && h < HR && data != 16'hDEAD);
        prev_ok = 1;
    endtask

    // gated lines add an invalid beat mid-line, an invalid beat after the
    // last column, invalid columns 10-11 and ignored valid columns 12-13.
    task automatic frame(int f, int v0, int v1, logic [1:0] mode, bit gated);
        for (int v = v0; v <= v1; v++) begin
            for (int x = 0; x < HR; x++) begin
                if (gated && x == HR - 1) beat(f, v, 3, 1'b0, 16'hDEAD, mode);
                beat(f, v, x, 1'b1, pix(f, v, x), mode);
            end
            if (gated) begin
                beat(f, v, HR - 1, 1'b0, 16'hDEAD, mode);
                beat(f, v, 10, 1'b0, 16'hDEAD, mode);
                beat(f, v, 11, 1'b0, 16'hDEAD, mode);
                beat(f, v, 12, 1'b1, 16'hDEAD, mode);
                beat(f, v, 13, 1'b1, 16'hDEAD, mode);
            end
        end
    endtask

    initial begin
        tbl[0]  = mk(0, 5, 4, 3, 3, 25, 35, 45);
        tbl[1]  = mk(0, 9, 9, 3, 7, 70, 80, 90);
        tbl[2]  = mk(1, 1, 4, 3, 9, 85, 95, 95);
        tbl[3]  = mk(1, 2, 4, 3, 0, 261, 261, 271);
        tbl[4]  = mk(1, 6, 0, 3, 4, 287, 297, 307);
        tbl[5]  = mk(2, 1, 4, 3, 9, 341, 351, 0);
        tbl[6]  = mk(2, 2, 4, 3, 0, 0, 517, 527);
        tbl[7]  = mk(3, 0, 3, 3, 8, 586, 596, 606);
        tbl[8]  = mk(3, 1, 4, 3, 9, 597, 607, 773);
        tbl[9]  = mk(3, 2, 4, 3, 0, 607, 773, 783);
        tbl[10] = mk(4, 1, 7, 3, 9, 856, 866, 1032);
        tbl[11] = mk(4, 5, 3, 3, 3, 1048, 1058, 1068);
        tbl[12] = mk(5, 9, 4, 3, 7, 1345, 1355, 1365);
        tbl[13] = mk(6, 2, 4, 3, 0, 1375, 1541, 1551);
        tbl[14] = mk(0, 7, 4, 5, 4, 25, 35, 45, 55, 65);
        tbl[15] = mk(1, 3, 4, 5, 0, 261, 261, 261, 271, 281);
        tbl[16] = mk(1, 4, 4, 5, 1, 261, 261, 271, 281, 291);
        tbl[17] = mk(1, 9, 2, 5, 6, 299, 309, 319, 329, 339);
        tbl[18] = mk(2, 1, 4, 5, 8, 321, 331, 341, 351, 0);
        tbl[19] = mk(2, 2, 4, 5, 9, 331, 341, 351, 0, 0);
        tbl[20] = mk(6, 1, 4, 5, 8, 1345, 1355, 1365, 1375, 1541);
        for (int t = 0; t < NV; t++) hits[t] = 0;

        rst_n = 1'b0; hcount_in = '0; vcount_in = '0; pixel_in = '0;
        valid_in = 1'b0; mode_in = M_RAW;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1'b1;

        frame(0, 0, VR - 1, M_RAW, 1'b0);
        frame(1, 0, VR - 1, M_CLAMP, 1'b0);
        frame(2, 0, VR - 1, M_ZERO, 1'b0);
        frame(3, 0, VR - 1, M_RSVD, 1'b0);
        frame(4, 0, VR - 1, M_RAW, 1'b1);

        // Reset in the middle of frame 5 at (v=4, x=6).
        frame(5, 0, 3, M_ZERO, 1'b0);
        for (int x = 0; x < 6; x++) beat(5, 4, x, 1'b1, pix(5, 4, x), M_ZERO);
        rst_n = 1'b0;
        #1;
        chk_zero("midframe reset");
        @(posedge clk);
        #1;
        chk_zero("midframe reset held");
        rst_n = 1'b1;
        prev_ok = 0;
        lines_done = 0;
        frame(5, 5, VR - 1, M_ZERO, 1'b0);
        frame(6, 0, 4, M_RAW, 1'b0);

        for (int t = 0; t < NV; t++) chk($sformatf("probe %0d reached", t), hits[t], 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
